mmu_walker: RTL and testbench

Parametrised Sv39/Sv48 page-table walker for the RV64 pipeline. It sits between the fetch/memory stages and the data bus, and translates one virtual address at a time into a physical address or a page fault. It generalises the fixed three-level walk to `LEVELS` levels and adds superpage handling, permission and fault classification, flush abort, and an optional last-translation cache.

---
 rtl/mmu_walker_pkg.sv | 56 +++++
 rtl/mmu_walker_pte_check.sv | 50 +++++
 rtl/mmu_walker.sv | 253 +++++++++++++++++++++++++
 tb/tb_mmu_walker.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_walker_pkg.sv
// mmu_walker_pkg: types and constants shared by the page-table walker.
//   ptw_state_t : walker FSM states (IDLE -> WALK -> OUTPUT -> IDLE)
//   ptw_kind_t  : access kind (load / store / fetch)
//   pte_t       : RISC-V Sv39/Sv48 page-table entry layout
//   satp_t      : satp CSR layout (mode / asid / root ppn)
//   leaf_paddr  : physical address from a leaf PTE at a given level
package mmu_walker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        OUTPUT = 2'd2
    } ptw_state_t;

    typedef enum logic [1:0] {
        KIND_LOAD  = 2'd0,
        KIND_STORE = 2'd1,
        KIND_FETCH = 2'd2
    } ptw_kind_t;

    typedef struct packed {
        logic [9:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        logic [3:0]  mode;
        logic [15:0] asid;
        logic [43:0] ppn;
    } satp_t;

    localparam logic [3:0] SATP_SV39 = 4'd8;
    localparam logic [3:0] SATP_SV48 = 4'd9;

    // A leaf at level L maps a 2^(12+9L) byte region: the low PPN fields are
    // replaced by the matching virtual address bits.
    function automatic logic [63:0] leaf_paddr(input pte_t       pte,
                                               input logic [1:0] lvl,
                                               input logic [63:0] vaddr);
        logic [43:0] ppn_hi;
        logic [63:0] off_mask;
        ppn_hi   = pte.ppn & ({44{1'b1}} << (9 * lvl));
        off_mask = ~({64{1'b1}} << (12 + 9 * lvl));
        return {8'd0, ppn_hi, 12'd0} | (vaddr & off_mask);
    endfunction

endpackage

// File: rtl/mmu_walker_pte_check.sv
// mmu_pte_check: combinational PTE classifier, used by the walk path and by
// the last-translation cache hit path.
// Ports:
//   pte     in  64  page-table entry
//   lvl     in  2   level the PTE was read at
//   kind    in  2   access kind (ptw_kind_t encoding)
//   is_leaf out 1   PTE is a leaf (R or X set)
//   fault   out 1   PTE produces a page fault for this access
module mmu_pte_check
    import mmu_walker_pkg::*;
(
    input  logic [63:0] pte,
    input  logic [1:0]  lvl,
    input  logic [1:0]  kind,
    output logic        is_leaf,
    output logic        fault
);

    pte_t p;
    logic perm_ok;
    logic misaligned;
    logic unused_bits;

    assign p           = pte;
    assign unused_bits = ^{p.reserved, p.rsw, p.g, p.u};

    always_comb begin
        is_leaf    = p.r || p.x;
        misaligned = (p.ppn & ~({44{1'b1}} << (9 * lvl))) != '0;
        perm_ok    = 1'b0;
        fault      = 1'b0;
        case (kind)
            KIND_LOAD:  perm_ok = p.r;
            KIND_STORE: perm_ok = p.w;
            KIND_FETCH: perm_ok = p.x;
            default:    perm_ok = 1'b0;
        endcase

        if (!p.v || (!p.r && p.w)) begin
            fault = 1'b1;
        end else if (!is_leaf) begin
            // A pointer at the last level has nowhere left to go.
            fault = (lvl == 2'd0);
        end else begin
            // A/D are software-managed: missing bits fault instead of being set.
            fault = !perm_ok || !p.a || ((kind == KIND_STORE) && !p.d) || misaligned;
        end
    end

endmodule

// File: rtl/mmu_walker.sv
// mmu_walker: Sv39/Sv48 page-table walker, one translation at a time.
// Optional feature: define MMU_WALKER_LASTHIT_EN to add a one-entry
// last-translation cache that skips the walk on a permitted hit.
// Parameters:
//   LEVELS    page-table depth (3 = Sv39, 4 = Sv48)
//   SATP_MODE satp.mode value that enables translation (8 = Sv39, 9 = Sv48)
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_vaddr/req_kind   translation request
//   satp, priv                               translation context
//   flush                                    abort walk, invalidate cache
//   mem_req_valid/mem_req_addr               PTE read request (held until ok)
//   mem_resp_ok/mem_resp_data                PTE read completion
//   resp_valid/resp_ready/resp_paddr/resp_fault  translation result
module mmu_walker
    import mmu_walker_pkg::*;
#(
    parameter int          LEVELS    = 3,
    parameter logic [3:0]  SATP_MODE = SATP_SV39
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_vaddr,
    input  logic [1:0]  req_kind,
    input  logic [63:0] satp,
    input  logic [1:0]  priv,
    input  logic        flush,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_ok,
    input  logic [63:0] mem_resp_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_paddr,
    output logic        resp_fault
);

    localparam int         VA_BITS = 12 + 9 * LEVELS;
    localparam logic [1:0] TOP_LVL = 2'(LEVELS - 1);

    ptw_state_t  state_q, state_d;
    logic [1:0]  lvl_q, lvl_d;
    logic [63:0] vaddr_q, vaddr_d;
    ptw_kind_t   kind_q, kind_d;
    logic [63:0] base_q, base_d;
    logic [63:0] paddr_q, paddr_d;
    logic        fault_q, fault_d;
    logic        abort_q, abort_d;

    satp_t       req_satp;
    pte_t        resp_pte;
    logic        translate;
    logic        canonical;
    logic        accept;
    logic [8:0]  vpn_cur;
    logic        w_leaf;
    logic        w_fault;
    logic        hit;
    logic [63:0] hit_paddr;
    logic [VA_BITS-1+1:VA_BITS-1] unused_canon_lsb;

    assign req_satp  = satp;
    assign resp_pte  = mem_resp_data;
    assign translate = (priv != 2'd3) && (req_satp.mode == SATP_MODE);
    // Bits above the VA width must all copy the top VA bit.
    assign canonical = (&req_vaddr[63:VA_BITS-1]) || (~|req_vaddr[63:VA_BITS-1]);
    // Flush has priority over a simultaneous request.
    assign accept    = req_valid && (state_q == IDLE) && !flush;
    assign vpn_cur   = 9'(vaddr_q >> (12 + 9 * lvl_q));
    assign unused_canon_lsb = '0;

    mmu_pte_check u_walk_check (
        .pte     (mem_resp_data),
        .lvl     (lvl_q),
        .kind    (kind_q),
        .is_leaf (w_leaf),
        .fault   (w_fault)
    );

`ifdef MMU_WALKER_LASTHIT_EN
    localparam int VPN_BITS = 9 * LEVELS;

    logic                c_valid_q;
    logic [VPN_BITS-1:0] c_vpn_q;
    logic [59:0]         c_satp_q;
    logic [1:0]          c_lvl_q;
    logic [63:0]         c_pte_q;
    logic [59:0]         satp_q;
    logic                c_leaf_unused;
    logic                c_fault;
    logic                satp_match;
    logic                vpn_match;
    logic                fill_en;

    // The cached leaf is re-checked against the new request's access kind.
    mmu_pte_check u_hit_check (
        .pte     (c_pte_q),
        .lvl     (c_lvl_q),
        .kind    (req_kind),
        .is_leaf (c_leaf_unused),
        .fault   (c_fault)
    );

    assign satp_match = (c_satp_q == satp[59:0]);
    assign vpn_match  = ((req_vaddr[VA_BITS-1:12] & ({VPN_BITS{1'b1}} << (9 * c_lvl_q)))
                         == c_vpn_q);
    assign hit        = c_valid_q && satp_match && vpn_match && !c_fault;
    assign hit_paddr  = leaf_paddr(pte_t'(c_pte_q), c_lvl_q, req_vaddr);
    assign fill_en    = (state_q == WALK) && mem_resp_ok && !abort_q && !flush
                        && w_leaf && !w_fault;

    // NOTE: the tag/data fields are small and are reset along with the valid
    // bit; mixing reset and non-reset flops in one async-reset process would
    // turn reset into a hidden enable on the data fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_valid_q <= 1'b0;
            c_vpn_q   <= '0;
            c_satp_q  <= '0;
            c_lvl_q   <= '0;
            c_pte_q   <= '0;
            satp_q    <= '0;
        end else begin
            if (accept) begin
                satp_q <= satp[59:0];
            end
            if (flush) begin
                c_valid_q <= 1'b0;
            end else if (accept && translate && canonical && !satp_match) begin
                c_valid_q <= 1'b0;
            end else if (fill_en) begin
                c_valid_q <= 1'b1;
                c_vpn_q   <= vaddr_q[VA_BITS-1:12] & ({VPN_BITS{1'b1}} << (9 * lvl_q));
                c_satp_q  <= satp_q;
                c_lvl_q   <= lvl_q;
                c_pte_q   <= mem_resp_data;
            end
        end
    end
`else
    logic [15:0] unused_asid;

    assign hit         = 1'b0;
    assign hit_paddr   = '0;
    assign unused_asid = req_satp.asid;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            vaddr_q <= '0;
            kind_q  <= KIND_LOAD;
            base_q  <= '0;
            paddr_q <= '0;
            fault_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            vaddr_q <= vaddr_d;
            kind_q  <= kind_d;
            base_q  <= base_d;
            paddr_q <= paddr_d;
            fault_q <= fault_d;
            abort_q <= abort_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        vaddr_d = vaddr_q;
        kind_d  = kind_q;
        base_d  = base_q;
        paddr_d = paddr_q;
        fault_d = fault_q;
        abort_d = abort_q;

        req_ready     = (state_q == IDLE);
        mem_req_valid = (state_q == WALK);
        mem_req_addr  = (state_q == WALK) ? base_q + 64'({vpn_cur, 3'b000}) : 64'd0;
        resp_valid    = (state_q == OUTPUT);
        resp_paddr    = (state_q == OUTPUT) ? paddr_q : 64'd0;
        resp_fault    = (state_q == OUTPUT) && fault_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    vaddr_d = req_vaddr;
                    kind_d  = ptw_kind_t'(req_kind);
                    lvl_d   = TOP_LVL;
                    abort_d = 1'b0;
                    base_d  = {8'd0, req_satp.ppn, 12'd0};
                    if (!translate) begin
                        state_d = OUTPUT;
                        paddr_d = req_vaddr;
                        fault_d = 1'b0;
                    end else if (!canonical) begin
                        state_d = OUTPUT;
                        paddr_d = '0;
                        fault_d = 1'b1;
                    end else if (hit) begin
                        state_d = OUTPUT;
                        paddr_d = hit_paddr;
                        fault_d = 1'b0;
                    end else begin
                        state_d = WALK;
                    end
                end
            end

            WALK: begin
                // The read is already on the bus, so a flush is remembered
                // and the walk is torn down once the response returns.
                if (flush) begin
                    abort_d = 1'b1;
                end
                if (mem_resp_ok) begin
                    if (abort_q || flush) begin
                        state_d = IDLE;
                    end else if (w_fault) begin
                        state_d = OUTPUT;
                        paddr_d = '0;
                        fault_d = 1'b1;
                    end else if (w_leaf) begin
                        state_d = OUTPUT;
                        paddr_d = leaf_paddr(resp_pte, lvl_q, vaddr_q);
                        fault_d = 1'b0;
                    end else begin
                        base_d = {8'd0, resp_pte.ppn, 12'd0};
                        lvl_d  = lvl_q - 2'd1;
                    end
                end
            end

            OUTPUT: begin
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmu_walker.sv
// tb_mmu_walker: directed bench for mmu_walker (Sv39 default). A small PTE
// table with programmable latency stands in for the memory side.
module tb_mmu_walker;
    import mmu_walker_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_vaddr;
    logic [1:0]  req_kind;
    logic [63:0] satp;
    logic [1:0]  priv;
    logic        flush;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_resp_ok;
    logic [63:0] mem_resp_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_paddr;
    logic        resp_fault;

    int n_vec = 0;
    int n_err = 0;
    int mem_lat = 0;
    int wait_cnt;
    int rd_cnt = 0;
    logic [63:0] rd_addr [64];

    localparam logic [63:0] TBL_ADDR [6] = '{
        64'h8000_0020, 64'h8000_18D0, 64'h8000_22B0,
        64'h8000_22B8, 64'h8000_1010, 64'h8000_1018};
    localparam logic [63:0] TBL_DATA [6] = '{
        64'h2000_0401,   // L2 pointer -> ppn 0x80001
        64'h2000_0801,   // L1 pointer -> ppn 0x80002
        64'h2004_8CC7,   // L0 leaf ppn 0x80123, D A W R V
        64'h2004_9043,   // L0 leaf ppn 0x80124, A R V (read-only)
        64'h2008_00C7,   // L1 leaf ppn 0x80200, aligned 2MiB
        64'h2008_04C7};  // L1 leaf ppn 0x80201, misaligned 2MiB

    localparam logic [63:0] SATP0 = 64'h8000_0000_0008_0000;  // Sv39, asid 0
    localparam logic [63:0] SATP1 = 64'h8000_1000_0008_0000;  // Sv39, asid 1

    mmu_walker dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_vaddr     (req_vaddr),
        .req_kind      (req_kind),
        .satp          (satp),
        .priv          (priv),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_ok   (mem_resp_ok),
        .mem_resp_data (mem_resp_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_paddr    (resp_paddr),
        .resp_fault    (resp_fault)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_resp_data = 64'd0;
        for (int i = 0; i < 6; i++) begin
            if (TBL_ADDR[i] == mem_req_addr) mem_resp_data = TBL_DATA[i];
        end
    end

    assign mem_resp_ok = mem_req_valid && (wait_cnt >= mem_lat);

    always @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt <= 0;
        else if (mem_req_valid && !mem_resp_ok) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (reset && mem_req_valid && mem_resp_ok) begin
            rd_addr[rd_cnt % 64] <= mem_req_addr;
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE, wait (bounded) for the result, hold it one
    // cycle with resp_ready low, then take it. cyc = cycles after acceptance.
    task automatic do_req(input string tag, input logic [63:0] va, input logic [1:0] kind,
                          input logic [63:0] sp, input logic [1:0] pv,
                          output logic [63:0] pa, output logic flt,
                          output int cyc, output int reads, output int base);
        check({tag, "_ready"}, req_ready, 1'b1);
        base      = rd_cnt;
        req_valid = 1'b1;
        req_vaddr = va;
        req_kind  = kind;
        satp      = sp;
        priv      = pv;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!resp_valid) cyc = -1;
        @(posedge clk); #1;
        check({tag, "_hold"}, resp_valid, 1'b1);
        pa    = resp_paddr;
        flt   = resp_fault;
        reads = rd_cnt - base;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_back2back"}, req_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pa;
        logic        flt;
        int          cyc, reads, base, n;

        reset = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_kind = '0;
        satp = '0; priv = '0; flush = 1'b0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, 64'd0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_paddr", resp_paddr, 64'd0);
        check("rst_resp_fault", resp_fault, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Bare: M-mode bypass.
        do_req("bare", 64'h8000_1234, KIND_LOAD, SATP0, 2'd3, pa, flt, cyc, reads, base);
        check("bare_paddr", pa, 64'h8000_1234);
        check("bare_fault", flt, 1'b0);
        check("bare_cyc", cyc, 1);
        check("bare_reads", reads, 0);

        // Sv39 4KiB walk, zero-wait memory.
        do_req("w4k", 64'h1_2345_6789, KIND_LOAD, SATP0, 2'd1, pa, flt, cyc, reads, base);
        check("w4k_paddr", pa, 64'h8012_3789);
        check("w4k_fault", flt, 1'b0);
        check("w4k_cyc", cyc, 4);
        check("w4k_reads", reads, 3);
        check("w4k_addr2", rd_addr[base % 64], 64'h8000_0020);
        check("w4k_addr1", rd_addr[(base + 1) % 64], 64'h8000_18D0);
        check("w4k_addr0", rd_addr[(base + 2) % 64], 64'h8000_22B0);

        // Same page again: cache hit when enabled, full walk otherwise.
        do_req("rep", 64'h1_2345_6ABC, KIND_LOAD, SATP0, 2'd1, pa, flt, cyc, reads, base);
        check("rep_paddr", pa, 64'h8012_3ABC);
        check("rep_fault", flt, 1'b0);
`ifdef MMU_WALKER_LASTHIT_EN
        check("rep_cyc", cyc, 1);
        check("rep_reads", reads, 0);
`else
        check("rep_cyc", cyc, 4);
        check("rep_reads", reads, 3);
`endif

        // New ASID: must walk again.
        do_req("asid", 64'h1_2345_6ABC, KIND_LOAD, SATP1, 2'd1, pa, flt, cyc, reads, base);
        check("asid_paddr", pa, 64'h8012_3ABC);
        check("asid_cyc", cyc, 4);
        check("asid_reads", reads, 3);

        // Fetch from a non-executable page: walks, faults at the leaf.
        do_req("fetch", 64'h1_2345_6000, KIND_FETCH, SATP1, 2'd1, pa, flt, cyc, reads, base);
        check("fetch_fault", flt, 1'b1);
        check("fetch_paddr", pa, 64'd0);
        check("fetch_reads", reads, 3);

        // Store to read-only leaf faults; load from it succeeds.
        do_req("st_ro", 64'h1_2345_7ABC, KIND_STORE, SATP1, 2'd1, pa, flt, cyc, reads, base);
        check("st_ro_fault", flt, 1'b1);
        check("st_ro_paddr", pa, 64'd0);
        do_req("ld_ro", 64'h1_2345_7ABC, KIND_LOAD, SATP1, 2'd1, pa, flt, cyc, reads, base);
        check("ld_ro_fault", flt, 1'b0);
        check("ld_ro_paddr", pa, 64'h8012_4ABC);

        // 2MiB superpage, aligned and misaligned.
        do_req("sp2m", 64'h1_0041_2345, KIND_LOAD, SATP1, 2'd1, pa, flt, cyc, reads, base);
        check("sp2m_paddr", pa, 64'h8021_2345);
        check("sp2m_fault", flt, 1'b0);
        check("sp2m_reads", reads, 2);
        check("sp2m_cyc", cyc, 3);
        do_req("sp2m_mis", 64'h1_0061_2345, KIND_LOAD, SATP1, 2'd1, pa, flt, cyc, reads, base);
        check("sp2m_mis_fault", flt, 1'b1);
        check("sp2m_mis_paddr", pa, 64'd0);

        // V=0 at the root level: one read then fault.
        do_req("inval", 64'h1_4000_0000, KIND_LOAD, SATP1, 2'd1, pa, flt, cyc, reads, base);
        check("inval_fault", flt, 1'b1);
        check("inval_reads", reads, 1);

        // Non-canonical: fault with no memory access.
        do_req("noncan", 64'h0000_8000_0000_0000, KIND_LOAD, SATP1, 2'd1, pa, flt, cyc, reads, base);
        check("noncan_fault", flt, 1'b1);
        check("noncan_reads", reads, 0);
        check("noncan_cyc", cyc, 1);

        // Flush while a 3-cycle read is outstanding.
        mem_lat   = 3;
        req_valid = 1'b1; req_vaddr = 64'h1_2345_6789; req_kind = KIND_LOAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("fl_issue", mem_req_valid, 1'b1);
        check("fl_addr", mem_req_addr, 64'h8000_0020);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_held", mem_req_valid, 1'b1);
        check("fl_held_addr", mem_req_addr, 64'h8000_0020);
        check("fl_busy", req_ready, 1'b0);
        n = 0;
        while (!mem_resp_ok && n < 10) begin
            check("fl_no_resp", resp_valid, 1'b0);
            @(posedge clk); #1;
            n++;
        end
        check("fl_ok_seen", mem_resp_ok, 1'b1);
        @(posedge clk); #1;
        check("fl_drop", mem_req_valid, 1'b0);
        check("fl_ready", req_ready, 1'b1);
        check("fl_resp", resp_valid, 1'b0);
        @(posedge clk); #1;
        check("fl_resp_later", resp_valid, 1'b0);

        // Flush beats a simultaneous request.
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flpri_ready", req_ready, 1'b1);
        check("flpri_noread", mem_req_valid, 1'b0);

        // Reset mid-walk: outputs return to reset values without a clock edge.
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_walking", mem_req_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("rmw_req_ready", req_ready, 1'b1);
        check("rmw_mem_req_valid", mem_req_valid, 1'b0);
        check("rmw_mem_req_addr", mem_req_addr, 64'd0);
        check("rmw_resp_valid", resp_valid, 1'b0);
        check("rmw_resp_paddr", resp_paddr, 64'd0);
        check("rmw_resp_fault", resp_fault, 1'b0);
        @(posedge clk); #1;
        reset   = 1'b1;
        mem_lat = 0;
        @(posedge clk); #1;

        // After reset the cache is empty: a full walk again.
        do_req("post", 64'h1_2345_6789, KIND_LOAD, SATP1, 2'd1, pa, flt, cyc, reads, base);
        check("post_paddr", pa, 64'h8012_3789);
        check("post_reads", reads, 3);
        check("post_cyc", cyc, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
